// File: rtl/ms_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ms_pkg
// Brief   : Shared widths and the command record for the ms_if register bus.
// Rev     : 1.0  initial release
// ============================================================================
package ms_pkg;

   localparam int MS_ADDR_W = 2;
   localparam int MS_DATA_W = 8;

   typedef struct packed {
      logic [MS_ADDR_W-1:0] addr;
      logic [MS_DATA_W-1:0] data;
   } ms_cmd_t;

endpackage
`default_nettype wire

// File: rtl/ms_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ms_cmd_fifo
// Brief   : Power-of-two command FIFO with occupancy count; head is read
//           combinationally from storage.
// Rev     : 1.0  initial release
// ============================================================================
module ms_cmd_fifo
   import ms_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = ms_cmd_t,
   parameter int  CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  T                 wr_data,
   input  logic             pop,
   output T                 rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] level
);

   localparam int c_PTR_W = $clog2(DEPTH);

   T                   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_push;
   logic               w_pop;

   assign full    = (r_count == CNT_W'(DEPTH));
   assign empty   = (r_count == '0);
   assign level   = r_count;
   assign rd_data = r_mem[r_rd_ptr];

   // Full blocks a push even if a pop happens on the same edge.
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ms_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : ms_cmd_master
// Brief   : FIFO-buffered write master for ms_if; data trails address by one
//           cycle. Define MS_CMD_STATS_EN for issue/stall counters.
// Rev     : 1.0  initial release
// ============================================================================
module ms_cmd_master
   import ms_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MS_ADDR_W-1:0] in_addr,
   input  logic [MS_DATA_W-1:0] in_data,
   output logic [MS_ADDR_W-1:0] m_addr,
   output logic [MS_DATA_W-1:0] m_data,
   input  logic                 sready,
   output logic                 busy,
   output logic [CNT_W-1:0]     level
`ifdef MS_CMD_STATS_EN
   ,
   output logic [15:0]          stat_issued,
   output logic [15:0]          stat_stall
`endif
);

   ms_cmd_t              w_in_cmd;
   ms_cmd_t              w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic [MS_DATA_W-1:0] r_a_data;
   logic                 r_pend;

   assign w_in_cmd.addr = in_addr;
   assign w_in_cmd.data = in_data;
   assign in_ready      = !w_full;
   assign w_pop         = sready && !w_empty;
   assign busy          = !w_empty || r_pend;

   ms_cmd_fifo #(
      .DEPTH (DEPTH),
      .T     (ms_cmd_t),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push    (in_valid),
      .wr_data (w_in_cmd),
      .pop     (w_pop),
      .rd_data (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .level   (level)
   );

   // m_data always follows a_data so each data phase lands one cycle after
   // its address phase, whether or not the slave is ready.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_addr   <= '0;
         r_a_data <= '0;
         m_data   <= '0;
         r_pend   <= 1'b0;
      end else begin
         m_data <= r_a_data;
         r_pend <= w_pop;
         if (w_pop) begin
            m_addr   <= w_head.addr;
            r_a_data <= w_head.data;
         end
      end
   end

`ifdef MS_CMD_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (w_pop) begin
            stat_issued <= stat_issued + 16'd1;
         end
         if (!sready && !w_empty) begin
            stat_stall <= stat_stall + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ms_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_ms_cmd_master
// Brief   : Self-checking bench for ms_cmd_master with a queue scoreboard and
//           a behavioural slave register bank.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ms_cmd_master;
   import ms_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_addr = '0;
   logic [7:0]       in_data = '0;
   logic [1:0]       m_addr;
   logic [7:0]       m_data;
   logic             sready = 1'b0;
   logic             busy;
   logic [CNT_W-1:0] level;
`ifdef MS_CMD_STATS_EN
   logic [15:0]      stat_issued;
   logic [15:0]      stat_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ms_cmd_master #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .m_addr   (m_addr),
      .m_data   (m_data),
      .sready   (sready),
      .busy     (busy),
      .level    (level)
`ifdef MS_CMD_STATS_EN
      ,
      .stat_issued (stat_issued),
      .stat_stall  (stat_stall)
`endif
   );

   // Scoreboard: accepted commands queue up, advances pop them into the
   // expected bus address / data pipeline.
   ms_cmd_t    q_sb[$];
   int         mdl_cnt;
   logic [1:0] e_addr;
   logic [7:0] e_a_data;
   logic [7:0] e_data;
   logic       e_pend;
   logic       w_adv;
   logic       w_acc;

   assign w_adv = sready && (mdl_cnt != 0);
   assign w_acc = in_valid && (mdl_cnt < DEPTH);

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_sb.delete();
         mdl_cnt  <= 0;
         e_addr   <= '0;
         e_a_data <= '0;
         e_data   <= '0;
         e_pend   <= 1'b0;
      end else begin
         e_data <= e_a_data;
         e_pend <= w_adv;
         if (w_adv) begin
            e_addr   <= q_sb[0].addr;
            e_a_data <= q_sb[0].data;
            void'(q_sb.pop_front());
         end
         if (w_acc) q_sb.push_back('{addr: in_addr, data: in_data});
         if (w_acc && !w_adv) mdl_cnt <= mdl_cnt + 1;
         else if (!w_acc && w_adv) mdl_cnt <= mdl_cnt - 1;
      end
   end

   // Slave register bank: data of cycle t goes to the address of cycle t-1.
   logic [7:0] sreg [4];
   logic [1:0] s_addr_q;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_addr_q <= '0;
      end else begin
         sreg[s_addr_q] <= m_data;
         s_addr_q       <= m_addr;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rst_init_level: got %0d expected 0", level); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_init_ready: got %b expected 1", in_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_init_busy: got %b expected 0", busy); end
      rstn = 1'b1;
      // issue one command so the bus registers are non-zero
      sready = 1'b1; in_valid = 1'b1; in_addr = 2'd3; in_data = 8'h5A;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); sready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_addr = 2'(i); in_data = 8'(8'h40 + i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL rst_pre_level: got %0d expected 3", level); end
      n_checks++; if (m_addr !== 2'd3 || m_data !== 8'h5A) begin n_fail++; $display("FAIL rst_pre_bus: got %0h/%0h expected 3/5a", m_addr, m_data); end
      #2 rstn = 1'b0;
      #1;
      n_checks++; if (m_addr !== 2'd0 || m_data !== 8'h00) begin n_fail++; $display("FAIL rst_bus: got %0h/%0h expected 0/0", m_addr, m_data); end
      n_checks++; if (level !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_state: got level=%0d busy=%b rdy=%b expected 0/0/1", level, busy, in_ready); end
      @(negedge clk); rstn = 1'b1; sready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (m_addr !== 2'd0 || m_data !== 8'h00 || level !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_after: got %0h/%0h level=%0d busy=%b expected 0/0/0/0", m_addr, m_data, level, busy); end
      end
   endtask

   task automatic test_single_write();
      sready = 1'b1; in_valid = 1'b1; in_addr = 2'd2; in_data = 8'hA5;
      @(negedge clk); in_valid = 1'b0;
      n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", level); end
      @(negedge clk);
      n_checks++; if (m_addr !== 2'd2) begin n_fail++; $display("FAIL single_addr: got %0h expected 2", m_addr); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
      @(negedge clk);
      n_checks++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %0h expected a5", m_data); end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b expected 0", busy); end
      n_checks++; if (sreg[2] !== 8'hA5) begin n_fail++; $display("FAIL single_slave: got %0h expected a5", sreg[2]); end
   endtask

   task automatic test_fill_overflow();
      logic [1:0] fa [5];
      logic [7:0] fd [5];
      fa = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
      fd = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
      sready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_addr = fa[i]; in_data = fd[i];
         @(negedge clk);
         n_checks++; if (int'(level) != ((i < 4) ? i + 1 : 4)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, level, (i < 4) ? i + 1 : 4); end
         n_checks++; if (in_ready !== (i < 3)) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b expected %b", i, in_ready, (i < 3)); end
      end
      in_valid = 1'b0; sready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++; if (m_addr !== fa[k] || m_addr !== e_addr) begin n_fail++; $display("FAIL drain_addr[%0d]: got %0h expected %0h", k, m_addr, fa[k]); end
         n_checks++; if (int'(level) != 3 - k) begin n_fail++; $display("FAIL drain_level[%0d]: got %0d expected %0d", k, level, 3 - k); end
         if (k > 0) begin
            n_checks++; if (m_data !== fd[k-1]) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h expected %0h", k, m_data, fd[k-1]); end
         end
      end
      @(negedge clk);
      n_checks++; if (m_data !== fd[3] || m_addr !== fa[3]) begin n_fail++; $display("FAIL drain_last: got %0h/%0h expected %0h/%0h", m_addr, m_data, fa[3], fd[3]); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy: got %b expected 0", busy); end
   endtask

   task automatic test_stall_burst();
      in_valid = 1'b0; sready = 1'b1;
      @(negedge clk); rstn = 1'b0;
      @(negedge clk); rstn = 1'b1;
      in_valid = 1'b1; in_addr = 2'd0; in_data = 8'h11;
      @(negedge clk);
      in_addr = 2'd1; in_data = 8'h22;
      @(negedge clk);
      n_checks++; if (m_addr !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_first: got addr=%0h busy=%b expected 0/1", m_addr, busy); end
      in_addr = 2'd3; in_data = 8'h33; sready = 1'b0;
      @(negedge clk); in_valid = 1'b0;
      n_checks++; if (m_addr !== 2'd0 || m_data !== 8'h11) begin n_fail++; $display("FAIL stall_hold1: got %0h/%0h expected 0/11", m_addr, m_data); end
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (m_addr !== 2'd0 || m_data !== 8'h11 || level !== 3'd2) begin n_fail++; $display("FAIL stall_hold3: got %0h/%0h level=%0d expected 0/11/2", m_addr, m_data, level); end
      sready = 1'b1;
      @(negedge clk);
      n_checks++; if (m_addr !== 2'd1) begin n_fail++; $display("FAIL stall_resume_b: got %0h expected 1", m_addr); end
      @(negedge clk);
      n_checks++; if (m_addr !== 2'd3 || m_data !== 8'h22) begin n_fail++; $display("FAIL stall_resume_d: got %0h/%0h expected 3/22", m_addr, m_data); end
      @(negedge clk);
      n_checks++; if (m_data !== 8'h33 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_last: got %0h busy=%b expected 33/0", m_data, busy); end
      @(negedge clk);
      n_checks++; if (sreg[0] !== 8'h11 || sreg[1] !== 8'h22 || sreg[3] !== 8'h33) begin n_fail++; $display("FAIL stall_slave: got %0h/%0h/%0h expected 11/22/33", sreg[0], sreg[1], sreg[3]); end
`ifdef MS_CMD_STATS_EN
      n_checks++; if (stat_issued !== 16'd3) begin n_fail++; $display("FAIL stat_issued: got %0d expected 3", stat_issued); end
      n_checks++; if (stat_stall !== 16'd3) begin n_fail++; $display("FAIL stat_stall: got %0d expected 3", stat_stall); end
`endif
   endtask

   task automatic test_back_to_back();
      sready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_addr = 2'(i); in_data = 8'(8'hC0 + i);
         @(negedge clk);
      end
      sready = 1'b1;
      for (int i = 2; i < 10; i++) begin
         in_addr = 2'(i); in_data = 8'(8'hC0 + i);
         @(negedge clk);
         n_checks++; if (level !== 3'd2 || int'(level) != mdl_cnt) begin n_fail++; $display("FAIL b2b_level[%0d]: got %0d expected 2", i, level); end
         n_checks++; if (m_addr !== 2'(i - 2) || m_addr !== e_addr) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0h expected %0h", i, m_addr, 2'(i - 2)); end
         if (i > 2) begin
            n_checks++; if (m_data !== 8'(8'hC0 + i - 3)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, m_data, 8'(8'hC0 + i - 3)); end
         end
      end
      in_valid = 1'b0;
      for (int i = 8; i < 10; i++) begin
         @(negedge clk);
         n_checks++; if (m_addr !== 2'(i) || m_data !== 8'(8'hC0 + i - 1)) begin n_fail++; $display("FAIL b2b_tail[%0d]: got %0h/%0h expected %0h/%0h", i, m_addr, m_data, 2'(i), 8'(8'hC0 + i - 1)); end
      end
      @(negedge clk);
      n_checks++; if (m_data !== 8'hC9 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %0h busy=%b expected c9/0", m_data, busy); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 80; c++) begin
         in_valid = ($urandom_range(0, 99) < 60);
         sready   = ($urandom_range(0, 99) < 50);
         in_addr  = 2'($urandom);
         in_data  = 8'($urandom);
         @(negedge clk);
         n_checks++; if (m_addr !== e_addr || m_data !== e_data) begin n_fail++; $display("FAIL rnd_bus[%0d]: got %0h/%0h expected %0h/%0h", c, m_addr, m_data, e_addr, e_data); end
         n_checks++; if (int'(level) != mdl_cnt || in_ready !== (mdl_cnt < DEPTH) || busy !== ((mdl_cnt != 0) || e_pend)) begin n_fail++; $display("FAIL rnd_state[%0d]: got level=%0d rdy=%b busy=%b expected level=%0d", c, level, in_ready, busy, mdl_cnt); end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill_overflow();
      test_stall_burst();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
